div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter: N, default 16, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled only on rising edge of clk.
REQ-004 in_valid  input  1  dividend/divisor pair offered.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 a_in  input  N  dividend, two's complement.
REQ-007 b_in  input  N  divisor, two's complement.
REQ-008 out_valid  output  1  result held on q_out/r_out/flags.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 q_out  output  N  quotient, two's complement.
REQ-011 r_out  output  N  remainder, two's complement.
REQ-012 dbz_out  output  1  divide-by-zero flag for current result.
REQ-013 ovf_out  output  1  quotient-overflow flag for current result.

Function
REQ-014 States SHALL be IDLE, BUSY, DONE.
- IDLE->BUSY on accept with b_in!=0.
- IDLE->DONE on accept with b_in==0.
- BUSY->DONE after exactly N iteration edges.
- DONE->IDLE on out_valid&out_ready.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready at a rising edge; operands SHALL be captured at that edge, and inputs outside accept SHALL be ignored.
REQ-016 The operation SHALL be unsigned restoring division on |a_in| and |b_in|, one quotient bit per BUSY cycle, MSB first, using an (N+1)-bit partial remainder and an iteration counter of ceil(log2(N+1)) bits.
REQ-017 Sign handling SHALL truncate toward zero: quotient negative iff signs differ; remainder takes the dividend's sign; |r| < |b|.
REQ-018 Latency SHALL be fixed: for accept in cycle c0 with b!=0, out_valid first high in cycle c0+N+1; with b==0, in cycle c0+1.
REQ-019 In DONE, out_valid SHALL be 1 and q_out/r_out/dbz_out/ovf_out SHALL be registered and stable until the handshake edge, regardless of in_valid/a_in/b_in.
REQ-020 Divide by zero SHALL give:
- dbz_out=1, ovf_out=0, r_out=a_in;
- q_out=2^(N-1)-1 if a_in>=0, else -2^(N-1).
REQ-021 Overflow case a_in=-2^(N-1), b_in=-1 SHALL give q_out=2^(N-1)-1, r_out=0, ovf_out=1, dbz_out=0, latency per REQ-018.
REQ-022 For all other cases, dbz_out and ovf_out SHALL be 0.
REQ-023 In IDLE and BUSY, out_valid SHALL be 0; q_out/r_out/flag values there are don't-care, except after reset (REQ-026).
REQ-024 No accept SHALL occur in DONE, including the handshake cycle; the next accept is possible one cycle after the handshake. Minimum throughput period is N+2 cycles.
REQ-025 |-2^(N-1)| SHALL be computed in the unsigned N-bit domain without loss (2^(N-1) unsigned).

Reset
REQ-026 reset high at an edge SHALL force state IDLE, counter 0, out_valid=0, q_out=0, r_out=0, dbz_out=0, ovf_out=0.
REQ-027 While reset is high, in_ready SHALL be 0 and no operand SHALL be captured.
REQ-028 reset asserted in BUSY or DONE SHALL abort the operation with no result ever presented; the next result SHALL depend only on post-reset operands.

Verification (N=16)
REQ-029 Accept a=100, b=7, out_ready=1 -> out_valid exactly 17 cycles after accept, q=14, r=2, flags 0, then IDLE with in_ready=1 next cycle.
REQ-030 Accept a=-100 (0xFF9C), b=7 -> q=0xFFF2 (-14), r=0xFFFE (-2); accept a=100, b=-7 -> q=0xFFF2, r=0x0002.
REQ-031 Accept a=0x8000, b=0xFFFF -> q=0x7FFF, r=0, ovf_out=1 after 17 cycles; accept a=0x8000, b=0x0001 -> q=0x8000, r=0, ovf_out=0.
REQ-032 Accept a=5, b=0 -> out_valid 1 cycle after accept, q=0x7FFF, r=5, dbz_out=1; accept a=-5, b=0 -> q=0x8000, r=0xFFFB.
REQ-033 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> outputs unchanged, in_ready=0; after handshake the new pair is accepted and computed correctly.
REQ-034 Assert reset in the 8th BUSY cycle of 1000/3 -> no out_valid; in_ready=1 the cycle after reset drops; subsequent 1000/3 -> q=333, r=1.

Source files
------------

// File: rtl/div_iter.sv
// Iterative signed divider: restoring division on operand magnitudes,
// one quotient bit per cycle, result held until taken by the consumer.
module div_iter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q_out,
  output logic [N-1:0] r_out,
  output logic         dbz_out,
  output logic         ovf_out
);

  localparam int CW = $clog2(N+1);
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N:0]    rem, rem_nxt;
  logic [N+1:0]  trial;
  logic [N-1:0]  quo, quo_nxt, dvs;
  logic [N-1:0]  a_mag, b_mag, q_fin, r_fin;
  logic          q_neg, r_neg, ovf_pend;
  logic          accept, last_iter;

  assign in_ready  = (state == IDLE) & ~reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign last_iter = (cnt == CW'(N-1));

  // Negating the most negative value wraps to itself, which is exactly
  // the correct unsigned magnitude 2^(N-1).
  assign a_mag = a_in[N-1] ? -a_in : a_in;
  assign b_mag = b_in[N-1] ? -b_in : b_in;

  always_comb begin
    trial   = {rem, quo[N-1]} - {2'b00, dvs};
    rem_nxt = trial[N+1] ? {rem[N-1:0], quo[N-1]} : trial[N:0];
    quo_nxt = {quo[N-2:0], ~trial[N+1]};
    q_fin   = q_neg ? -quo_nxt : quo_nxt;
    r_fin   = r_neg ? -rem_nxt[N-1:0] : rem_nxt[N-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (b_in == '0) ? DONE : BUSY;
      BUSY: if (last_iter) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      ovf_pend <= 1'b0;
      q_out    <= '0;
      r_out    <= '0;
      dbz_out  <= 1'b0;
      ovf_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt      <= '0;
          rem      <= '0;
          quo      <= a_mag;
          dvs      <= b_mag;
          q_neg    <= a_in[N-1] ^ b_in[N-1];
          r_neg    <= a_in[N-1];
          ovf_pend <= (a_in == MIN_NEG) && (b_in == '1);
          // Divide by zero skips the iterations and saturates toward a's sign.
          if (b_in == '0) begin
            q_out   <= a_in[N-1] ? MIN_NEG : MAX_POS;
            r_out   <= a_in;
            dbz_out <= 1'b1;
            ovf_out <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (last_iter) begin
            q_out   <= ovf_pend ? MAX_POS : q_fin;
            r_out   <= ovf_pend ? '0 : r_fin;
            dbz_out <= 1'b0;
            ovf_out <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
